counter_timer_multi: RTL and testbench
======================================

Name: counter_timer_multi

Overview:
- Parametrised multi-channel successor to the management SoC counter/timer; N independent WIDTH-bit channels sit behind one register port.
- Each channel counts up or down, runs one-shot or continuous, and can chain to the channel below it to form a wider counter.
- Each channel provides a single-cycle terminal pulse and a sticky, maskable interrupt.
- The block sits behind the SoC's Wishbone register adapter; tc pulses and irq lines route to the SoC IRQ/GPIO logic.

Parameters:
- WIDTH, 32, counter and register width; must be a multiple of 8 and at most 32.
- CHANNELS, 2, number of timer channels, 1..8.
- CHW (localparam), max(1, clog2(CHANNELS)), channel-select width.

Ports:
- clkin  input  1  block clock; all state advances on its rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- reg_sel  input  CHW  channel index for the current access.
- reg_addr  input  2  register select: 0=CFG, 1=VALUE (reload/limit), 2=DATA (current count), 3=reserved.
- reg_we  input  WIDTH/8  per-byte write enables.
- reg_re  input  1  read strobe.
- reg_di  input  WIDTH  write data.
- reg_do  output  WIDTH  read data, registered.
- tc  output  CHANNELS  per-channel terminal-count pulse, one cycle wide.
- irq  output  CHANNELS  per-channel interrupt, level.

Behaviour:
- Reset: resetn low asynchronously clears CFG, VALUE, DATA, pending flags, reg_do, tc and irq in every channel. Reset mid-count takes effect immediately; no event completes.
- CFG bits:
  - [0] EN.
  - [1] ONESHOT.
  - [2] UP (1=up, 0=down).
  - [3] CHAIN (ignored on ch0; reads 0 there).
  - [4] IRQEN.
  - [5] PEND (sticky; writing 1 clears it, writing 0 has no effect).
  - All other bits read 0.
- Tick: channel i ticks in a cycle when EN=1 and either CHAIN=0, or CHAIN=1 and tc[i-1] fires in that same cycle. Chain ripple is combinational within the cycle.
- Down mode, on a tick:
  - DATA!=0: DATA decrements.
  - DATA==0: terminal event. Continuous: DATA<=VALUE. One-shot: DATA holds 0 and EN clears.
- Up mode, on a tick:
  - DATA!=VALUE: DATA increments (wraps mod 2^WIDTH if DATA>VALUE).
  - DATA==VALUE: terminal event. Continuous: DATA<=0. One-shot: DATA holds and EN clears.
- Continuous period is VALUE+1 ticks.
- Terminal event effects:
  - tc[i]=1 for exactly that cycle (registered; asserted the cycle after the terminal clock edge).
  - PEND sets.
  - irq[i] = PEND & IRQEN.
- Writes take effect at the clock edge and are byte-masked by reg_we. A register write to DATA or CFG in the same cycle as a tick wins over the tick's update.
- Enable timing: EN written 0->1 means the first tick occurs on the following cycle.
- Write collisions on PEND: a PEND set by a terminal event in the same cycle as a W1C leaves PEND=1.
- Reads: reg_re=1 loads reg_do with the addressed register at that edge. reg_do otherwise holds.
- Invalid accesses: reg_sel >= CHANNELS or reg_addr=3 reads 0 and ignores writes.
- VALUE=0: down-continuous fires tc every tick; up-continuous fires tc every tick.

Test Plan:
1. ch0 VALUE=DATA=0x0F, CFG=EN|ONESHOT (down) -> DATA reaches 0 after 15 cycles; tc[0] pulses once, 16 cycles after enable; EN reads 0; DATA stays 0x00.
2. ch0 VALUE=4, DATA=0, CFG=EN|UP|IRQEN -> DATA sequence 0,1,2,3,4,0,...; tc[0] every 5 cycles; irq[0]=1 after first wrap; CFG write 0x20 clears irq[0] until the next wrap.
3. ch0 VALUE=DATA=9 continuous down; ch1 VALUE=DATA=2, CFG=EN|CHAIN -> ch1 DATA steps 2->1->0 at ch0 terminals 1 and 2; tc[1] coincides with the 3rd tc[0] (cycle 30 after enable); ch1 DATA reloads to 2.
4. ch0 counting down from 0x12BC; write DATA=0x5D with reg_we all-ones in a ticking cycle -> read-back 0x5D, then 0x5C on the next tick; no tc.
5. VALUE=0; write 0xDCBA7CFB with reg_we=4'b0011 -> read VALUE = 0x00007CFB. Write reg_sel=CHANNELS -> no channel changes; read there returns 0.
6. Continuous counting on both channels with irq[0] high; pulse resetn low for 1 ns between edges -> DATA/CFG/irq/tc all 0 immediately; no counting after release until reprogrammed.

Source files
------------

// File: rtl/counter_timer_multi.sv
// counter_timer_multi: N independent WIDTH-bit counter/timer channels behind
// one byte-masked register port. Each channel counts up or down, one-shot or
// continuous, can chain off the terminal event of the channel below it, and
// provides a one-cycle terminal pulse (tc) plus a sticky, maskable interrupt.
//
// Register map per channel (reg_sel picks the channel):
//   0 CFG   : [0] EN [1] ONESHOT [2] UP [3] CHAIN [4] IRQEN [5] PEND (W1C)
//   1 VALUE : reload value (down) / limit (up)
//   2 DATA  : current count
//   3       : reserved, reads 0, writes ignored
// Handshake: a register access is a single-cycle strobe with no back-pressure.
// Writes (reg_we != 0) commit at the next clkin edge. A read (reg_re=1) loads
// reg_do at that edge with the pre-edge register value; reg_do then holds.
module counter_timer_multi #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int NBYTES  = WIDTH / 8
) (
    input  logic                clkin,
    input  logic                resetn,
    input  logic [CHW-1:0]      reg_sel,
    input  logic [1:0]          reg_addr,
    input  logic [NBYTES-1:0]   reg_we,
    input  logic                reg_re,
    input  logic [WIDTH-1:0]    reg_di,
    output logic [WIDTH-1:0]    reg_do,
    output logic [CHANNELS-1:0] tc,
    output logic [CHANNELS-1:0] irq
);

    localparam int CFG_EN      = 0;
    localparam int CFG_ONESHOT = 1;
    localparam int CFG_UP      = 2;
    localparam int CFG_CHAIN   = 3;
    localparam int CFG_IRQEN   = 4;
    localparam int CFG_PEND    = 5;

    localparam logic [1:0] ADDR_CFG   = 2'd0;
    localparam logic [1:0] ADDR_VALUE = 2'd1;
    localparam logic [1:0] ADDR_DATA  = 2'd2;

    logic [5:0]          cfg_q   [CHANNELS];
    logic [5:0]          cfg_d   [CHANNELS];
    logic [WIDTH-1:0]    value_q [CHANNELS];
    logic [WIDTH-1:0]    value_d [CHANNELS];
    logic [WIDTH-1:0]    data_q  [CHANNELS];
    logic [WIDTH-1:0]    data_d  [CHANNELS];
    logic [CHANNELS-1:0] tc_q;
    logic [CHANNELS-1:0] tc_d;
    logic [WIDTH-1:0]    reg_do_q;
    logic [WIDTH-1:0]    reg_do_d;
    logic [WIDTH-1:0]    rdata;

    // Replace only the bytes whose enable is set.
    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0]  old_v,
        input logic [WIDTH-1:0]  new_v,
        input logic [NBYTES-1:0] be
    );
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) begin
                r[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return r;
    endfunction

    // Read mux; out-of-range channels and the reserved address return 0.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (reg_sel == CHW'(i)) begin
                case (reg_addr)
                    ADDR_CFG:   rdata = {{(WIDTH-6){1'b0}}, cfg_q[i]};
                    ADDR_VALUE: rdata = value_q[i];
                    ADDR_DATA:  rdata = data_q[i];
                    default:    rdata = '0;
                endcase
            end
        end
        reg_do_d = reg_re ? rdata : reg_do_q;
    end

    // Per-channel next state: tick/terminal evaluation with the chain
    // rippling upward inside the cycle, then register writes layered on top.
    always_comb begin
        logic carry;
        logic tick;
        logic term;
        logic hit;
        carry = 1'b0;
        tick  = 1'b0;
        term  = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_d[i]   = cfg_q[i];
            value_d[i] = value_q[i];
            data_d[i]  = data_q[i];
            term       = 1'b0;
            tick       = cfg_q[i][CFG_EN] && (!cfg_q[i][CFG_CHAIN] || carry);
            if (tick) begin
                if (cfg_q[i][CFG_UP]) begin
                    if (data_q[i] != value_q[i]) begin
                        data_d[i] = data_q[i] + 1'b1;
                    end else begin
                        term = 1'b1;
                        if (!cfg_q[i][CFG_ONESHOT]) begin
                            data_d[i] = '0;
                        end
                    end
                end else begin
                    if (data_q[i] != '0) begin
                        data_d[i] = data_q[i] - 1'b1;
                    end else begin
                        term = 1'b1;
                        if (!cfg_q[i][CFG_ONESHOT]) begin
                            data_d[i] = value_q[i];
                        end
                    end
                end
                if (term && cfg_q[i][CFG_ONESHOT]) begin
                    cfg_d[i][CFG_EN] = 1'b0;
                end
            end
            tc_d[i]           = term;
            cfg_d[i][CFG_PEND] = cfg_q[i][CFG_PEND] | term;
            carry             = term;

            hit = (reg_sel == CHW'(i));
            // CFG write overrides the tick; a terminal event still sets PEND.
            if (hit && (reg_addr == ADDR_CFG) && reg_we[0]) begin
                cfg_d[i][4:0] = reg_di[4:0];
                if (i == 0) begin
                    cfg_d[i][CFG_CHAIN] = 1'b0;
                end
                cfg_d[i][CFG_PEND] = (cfg_q[i][CFG_PEND] & ~reg_di[CFG_PEND]) | term;
            end
            if (hit && (reg_addr == ADDR_VALUE)) begin
                value_d[i] = byte_merge(value_q[i], reg_di, reg_we);
            end
            // DATA write overrides the written bytes of the tick result.
            if (hit && (reg_addr == ADDR_DATA)) begin
                data_d[i] = byte_merge(data_d[i], reg_di, reg_we);
            end
        end
    end

    // Interrupt level follows the sticky pending flag gated by IRQEN.
    always_comb begin
        irq = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            irq[i] = cfg_q[i][CFG_PEND] & cfg_q[i][CFG_IRQEN];
        end
    end

    // State registers; asynchronous reset clears every channel at once.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cfg_q[i]   <= '0;
                value_q[i] <= '0;
                data_q[i]  <= '0;
            end
            tc_q     <= '0;
            reg_do_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cfg_q[i]   <= cfg_d[i];
                value_q[i] <= value_d[i];
                data_q[i]  <= data_d[i];
            end
            tc_q     <= tc_d;
            reg_do_q <= reg_do_d;
        end
    end

    assign tc     = tc_q;
    assign reg_do = reg_do_q;

endmodule

// File: tb/tb_counter_timer_multi.sv
// Bench for counter_timer_multi (3 channels so an out-of-range select exists).
// The driver applies one register access per cycle at the falling edge and
// advances a behavioural model; the monitor compares tc/irq/reg_do shortly
// after each rising edge, plus directed read-back constants from exp_q.
module tb_counter_timer_multi;
    localparam int W   = 32;
    localparam int CH  = 3;
    localparam int CHW = 2;
    localparam int BE  = W / 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [CHW-1:0] reg_sel = '0;
    logic [1:0]    reg_addr = '0;
    logic [BE-1:0] reg_we = '0;
    logic          reg_re = 1'b0;
    logic [W-1:0]  reg_di = '0;
    logic [W-1:0]  reg_do;
    logic [CH-1:0] tc;
    logic [CH-1:0] irq;

    counter_timer_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clkin   (clk),
        .resetn  (resetn),
        .reg_sel (reg_sel),
        .reg_addr(reg_addr),
        .reg_we  (reg_we),
        .reg_re  (reg_re),
        .reg_di  (reg_di),
        .reg_do  (reg_do),
        .tc      (tc),
        .irq     (irq)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: one record per channel.
    typedef struct {
        bit         en, oneshot, up, chain, irqen, pend;
        bit [W-1:0] value, data;
    } ch_t;
    ch_t        m [CH];
    bit [W-1:0] m_rdo;

    typedef struct {
        bit [CH-1:0] tc, irq;
        bit [W-1:0]  rdo;
        bit          chk;
    } ev_t;
    ev_t          ev_q[$];
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int tc_cnt [CH];

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    endfunction

    function automatic bit [W-1:0] merge(bit [W-1:0] old_v, bit [W-1:0] din, bit [BE-1:0] we);
        bit [W-1:0] r;
        r = old_v;
        for (int b = 0; b < BE; b++) if (we[b]) r[b*8 +: 8] = din[b*8 +: 8];
        return r;
    endfunction

    function automatic bit [W-1:0] model_read(int sel, int addr);
        if (sel >= CH || addr == 3) return '0;
        if (addr == 0)
            return {{(W-6){1'b0}}, m[sel].pend, m[sel].irqen, m[sel].chain,
                    m[sel].up, m[sel].oneshot, m[sel].en};
        if (addr == 1) return m[sel].value;
        return m[sel].data;
    endfunction

    // One clock edge of the specified behaviour.
    function automatic ev_t model_cycle(int sel, int addr, bit [BE-1:0] we, bit re, bit [W-1:0] di);
        ev_t e;
        ch_t nm [CH];
        bit  below_fired, ticks, term, acc;
        nm = m;
        below_fired = 0;
        e.tc = '0;
        e.irq = '0;
        e.chk = 0;
        if (re) m_rdo = model_read(sel, addr);
        for (int i = 0; i < CH; i++) begin
            ticks = m[i].en && (!m[i].chain || below_fired);
            term  = 0;
            if (ticks) begin
                term = m[i].up ? (m[i].data == m[i].value) : (m[i].data == 0);
                if (!term) nm[i].data = m[i].up ? m[i].data + W'(1) : m[i].data - W'(1);
                else if (m[i].oneshot) begin
                    nm[i].en = 0;
                    nm[i].data = m[i].up ? m[i].data : '0;
                end else nm[i].data = m[i].up ? '0 : m[i].value;
            end
            e.tc[i] = term;
            below_fired = term;
            acc = (sel == i) && (addr != 3) && (we != 0);
            if (acc && addr == 0 && we[0]) begin
                nm[i].en      = di[0];
                nm[i].oneshot = di[1];
                nm[i].up      = di[2];
                nm[i].chain   = (i != 0) && di[3];
                nm[i].irqen   = di[4];
                nm[i].pend    = (m[i].pend && !di[5]) || term;
            end else nm[i].pend = m[i].pend || term;
            if (acc && addr == 1) nm[i].value = merge(m[i].value, di, we);
            if (acc && addr == 2) nm[i].data  = merge(nm[i].data, di, we);
        end
        m = nm;
        for (int i = 0; i < CH; i++) e.irq[i] = m[i].pend && m[i].irqen;
        e.rdo = m_rdo;
        return e;
    endfunction

    // Driver tasks
    task automatic step(input int sel, input int addr, input bit [BE-1:0] we, input bit re,
                        input bit [W-1:0] di, input bit chk = 0, input bit [W-1:0] expv = '0);
        ev_t e;
        @(negedge clk);
        reg_sel  = CHW'(sel);
        reg_addr = 2'(addr);
        reg_we   = we;
        reg_re   = re;
        reg_di   = di;
        e = model_cycle(sel, addr, we, re, di);
        e.chk = chk;
        if (chk) exp_q.push_back(expv);
        ev_q.push_back(e);
    endtask

    task automatic wr(input int sel, input int addr, input bit [W-1:0] di);
        step(sel, addr, '1, 0, di);
    endtask

    task automatic rd_expect(input int sel, input int addr, input bit [W-1:0] expv);
        step(sel, addr, '0, 1, '0, 1, expv);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_tc", W'(tc), '0);
        check("rst_irq", W'(irq), '0);
        check("rst_reg_do", reg_do, '0);
        resetn = 1'b1;
        for (int i = 0; i < CH; i++) m[i] = '{default: 0};
        m_rdo = '0;
    endtask

    // Monitor / scoreboard
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #2;
            if (ev_q.size() > 0) begin
                e = ev_q.pop_front();
                check("tc", W'(tc), W'(e.tc));
                check("irq", W'(irq), W'(e.irq));
                check("reg_do", reg_do, e.rdo);
                for (int i = 0; i < CH; i++) if (tc[i]) tc_cnt[i]++;
                if (e.chk && exp_q.size() > 0) check("readback", reg_do, exp_q.pop_front());
            end
        end
    end

    // Stimulus
    initial begin
        int c0, c1, sel, addr;
        bit [BE-1:0] we;
        bit re;
        bit [W-1:0] di;

        repeat (3) @(negedge clk);
        check("reset_tc", W'(tc), '0);
        check("reset_irq", W'(irq), '0);
        check("reset_reg_do", reg_do, '0);
        resetn = 1'b1;
        rd_expect(0, 0, '0);
        rd_expect(1, 2, '0);

        // One-shot down from 0x0F.
        wr(0, 1, 32'h0F);
        wr(0, 2, 32'h0F);
        c0 = tc_cnt[0];
        wr(0, 0, 32'h03);
        idle(20);
        check("t1_tc_count", W'(tc_cnt[0] - c0), 1);
        rd_expect(0, 2, 32'h0);
        rd_expect(0, 0, 32'h22);
        idle(5);
        rd_expect(0, 2, 32'h0);

        // Up continuous, limit 4, with interrupt and W1C.
        wr(0, 0, 32'h20);
        wr(0, 1, 32'h4);
        wr(0, 2, 32'h0);
        wr(0, 0, 32'h15);
        rd_expect(0, 2, 0);
        rd_expect(0, 2, 1);
        rd_expect(0, 2, 2);
        rd_expect(0, 2, 3);
        rd_expect(0, 2, 4);
        rd_expect(0, 2, 0);
        rd_expect(0, 2, 1);
        check("t2_irq_set", W'(irq[0]), 1);
        wr(0, 0, 32'h35);
        idle(1);
        check("t2_irq_cleared", W'(irq[0]), 0);
        idle(4);
        check("t2_irq_reset", W'(irq[0]), 1);
        c0 = tc_cnt[0];
        idle(25);
        check("t2_tc_count", W'(tc_cnt[0] - c0), 5);

        // Chain ch1 off ch0.
        wr(0, 0, 32'h20);
        wr(1, 0, 32'h20);
        wr(0, 1, 9);
        wr(0, 2, 9);
        wr(1, 1, 2);
        wr(1, 2, 2);
        wr(1, 0, 32'h09);
        idle(2);
        c0 = tc_cnt[0];
        c1 = tc_cnt[1];
        wr(0, 0, 32'h01);
        idle(34);
        check("t3_tc0_count", W'(tc_cnt[0] - c0), 3);
        check("t3_tc1_count", W'(tc_cnt[1] - c1), 1);
        rd_expect(1, 2, 2);

        // DATA write collides with a tick.
        wr(0, 0, 32'h20);
        wr(1, 0, 32'h20);
        wr(0, 1, 32'hFFFF);
        wr(0, 2, 32'h12BC);
        idle(2);
        c0 = tc_cnt[0];
        wr(0, 0, 32'h01);
        idle(3);
        wr(0, 2, 32'h5D);
        rd_expect(0, 2, 32'h5D);
        rd_expect(0, 2, 32'h5C);
        idle(2);
        check("t4_no_tc", W'(tc_cnt[0] - c0), 0);

        // Byte masking and invalid accesses.
        wr(0, 0, 32'h20);
        wr(0, 1, 32'h0);
        step(0, 1, 4'b0011, 0, 32'hDCBA7CFB);
        rd_expect(0, 1, 32'h00007CFB);
        step(3, 0, '1, 0, 32'h3F);
        step(3, 1, '1, 0, 32'h1234);
        step(3, 2, '1, 0, 32'h5678);
        step(0, 3, '1, 0, 32'h9ABC);
        rd_expect(3, 0, 0);
        rd_expect(3, 2, 0);
        rd_expect(0, 3, 0);
        rd_expect(0, 1, 32'h00007CFB);
        rd_expect(1, 0, 0);
        rd_expect(2, 0, 0);

        // VALUE=0: down (ch1) and up (ch2) fire on every tick.
        for (int ch = 1; ch < CH; ch++) begin
            wr(ch, 1, 0);
            wr(ch, 2, 0);
            idle(2);
            c0 = tc_cnt[ch];
            wr(ch, 0, (ch == 1) ? 32'h01 : 32'h05);
            idle(10);
            wr(ch, 0, 32'h20);
            idle(3);
            check("v0_tc_count", W'(tc_cnt[ch] - c0), 11);
        end

        // Asynchronous reset mid-count.
        wr(0, 1, 3);
        wr(0, 2, 3);
        wr(1, 1, 5);
        wr(1, 2, 5);
        wr(0, 0, 32'h11);
        wr(1, 0, 32'h01);
        idle(10);
        check("t6_irq_before", W'(irq[0]), 1);
        reset_pulse();
        c0 = tc_cnt[0];
        c1 = tc_cnt[1];
        idle(5);
        rd_expect(0, 2, 0);
        rd_expect(1, 2, 0);
        rd_expect(0, 0, 0);
        rd_expect(1, 1, 0);
        idle(5);
        check("t6_no_tc0", W'(tc_cnt[0] - c0), 0);
        check("t6_no_tc1", W'(tc_cnt[1] - c1), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            sel  = $urandom_range(0, 3);
            addr = $urandom_range(0, 3);
            we   = ($urandom_range(0, 3) == 0) ? BE'($urandom) : '0;
            re   = 1'($urandom_range(0, 1));
            di   = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            if (addr == 0 && we != 0) begin
                we[0] = 1'b1;
                di = W'($urandom_range(0, 63));
            end
            step(sel, addr, we, re, di);
        end

        idle(4);
        @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
